scan_decoder: RTL

Parametrised, registered n-to-2^n line decoder with an active-low enable and selectable output polarity.
- Direct mode: registered decode of an external select.
- Scan mode: autonomously steps a one-hot output across a programmable range, with dwell and optional blanking. Used for multiplexed display digit/row drive and for strobing banks of peripherals.
- Successor to the fixed 2-to-4 gate-level decoder in the digital-logic library.

---
 rtl/scan_decoder_pkg.sv | 15 +
 rtl/scan_decoder_if.sv | 28 ++
 rtl/scan_decoder_onehot_dec.sv | 16 +
 rtl/scan_decoder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared encodings for the scan decoder.
//   MODE_DIRECT / MODE_SCAN : values of the mode input.
//   state_e                 : scan FSM states (2-bit).
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_BLANK = 2'd2
    } state_e;

endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control inputs and decoded outputs of scan_decoder.
//   master: drives en_n, mode, sel, scan_last; observes d_out, cur_idx, step, wrap.
//   slave : the decoder side.
interface scan_decoder_if #(
    parameter int SEL_W = 2
);
    localparam int N_OUT = 2**SEL_W;

    logic             en_n;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] scan_last;
    logic [N_OUT-1:0] d_out;
    logic [SEL_W-1:0] cur_idx;
    logic             step;
    logic             wrap;

    modport master (
        output en_n, mode, sel, scan_last,
        input  d_out, cur_idx, step, wrap
    );

    modport slave (
        input  en_n, mode, sel, scan_last,
        output d_out, cur_idx, step, wrap
    );

endinterface

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec: combinational SEL_W -> 2**SEL_W one-hot decoder.
//   en  : active-high enable; 0 forces all outputs low.
//   sel : index to decode.
//   y   : one-hot result (active high).
module onehot_dec #(
    parameter  int SEL_W = 2,
    localparam int N_OUT = 2**SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] y
);

    assign y = en ? (N_OUT'(1) << sel) : '0;

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered n-to-2^n decoder with active-low enable, selectable
// output polarity, and an auto-scan mode that walks a one-hot output across
// indices 0..scan_last with DIV dwell cycles and BLANK all-inactive cycles each.
//   clk, rst : clock, synchronous active-high reset.
//   bus      : en_n, mode, sel, scan_last in; d_out, cur_idx, step, wrap out.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int DIV        = 4,
    parameter int BLANK      = 1
) (
    input  logic           clk,
    input  logic           rst,
    scan_decoder_if.slave  bus
);

    localparam int N_OUT = 2**SEL_W;
    localparam int DW_W  = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;
    localparam int BW_W  = ($clog2(BLANK + 1) > 0) ? $clog2(BLANK + 1) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DIV - 1);
    localparam logic [BW_W-1:0] BL_LAST = BW_W'((BLANK > 0) ? BLANK - 1 : 0);

    state_e            state_q, state_d;
    logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [BW_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [SEL_W-1:0]  cur_idx_q, cur_idx_d;
    logic [N_OUT-1:0]  h_q, h_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;

    logic              scan_on, dwell_last, blank_last, adv, dec_en;
    logic [SEL_W-1:0]  next_idx;

    assign scan_on    = ~bus.en_n & (bus.mode == MODE_SCAN);
    assign dwell_last = (dwell_cnt_q == DW_LAST);
    assign blank_last = (blank_cnt_q == BL_LAST);
    // scan_last is sampled only here, so a change lands at the next advance;
    // an index already beyond a lowered limit wraps to 0.
    assign next_idx   = (cur_idx_q >= bus.scan_last) ? '0 : cur_idx_q + SEL_W'(1);
    // Advance after the last dwell cycle (no blanking) or the last blank cycle.
    assign adv = scan_on &
                 (((state_q == S_DWELL) & dwell_last & (BLANK == 0)) |
                  ((state_q == S_BLANK) & blank_last));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
            cur_idx_q   <= '0;
            h_q         <= '0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            cur_idx_q   <= cur_idx_d;
            h_q         <= h_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
        end
    end

    // Next-state and dwell/blank counters
    always_comb begin
        state_d     = state_q;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        if (!scan_on) begin
            state_d     = S_IDLE;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_DWELL;
                    dwell_cnt_d = '0;
                end
                S_DWELL: begin
                    if (!dwell_last) begin
                        dwell_cnt_d = dwell_cnt_q + DW_W'(1);
                    end else if (BLANK > 0) begin
                        state_d     = S_BLANK;
                        blank_cnt_d = '0;
                    end else begin
                        dwell_cnt_d = '0;
                    end
                end
                S_BLANK: begin
                    if (!blank_last) begin
                        blank_cnt_d = blank_cnt_q + BW_W'(1);
                    end else begin
                        state_d     = S_DWELL;
                        dwell_cnt_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs: index, pulses, and the one-hot source index
    always_comb begin
        cur_idx_d = cur_idx_q;
        step_d    = adv;
        wrap_d    = adv & (next_idx == '0);
        if (!bus.en_n) begin
            if (bus.mode == MODE_DIRECT)
                cur_idx_d = bus.sel;
            else if (state_q == S_IDLE)
                cur_idx_d = '0;          // scan always restarts at index 0
            else if (adv)
                cur_idx_d = next_idx;
        end
    end

    // Lines are lit in direct mode and while dwelling; blank/idle/disabled are dark.
    assign dec_en = ~bus.en_n & ((bus.mode == MODE_DIRECT) | (state_d == S_DWELL));

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .en  (dec_en),
        .sel (cur_idx_d),
        .y   (h_d)
    );

    assign bus.d_out   = (ACTIVE_LOW != 0) ? ~h_q : h_q;
    assign bus.cur_idx = cur_idx_q;
    assign bus.step    = step_q;
    assign bus.wrap    = wrap_q;

endmodule
